// File: rtl/xvec_rf_pkg.sv
// Shared types and defaults for the parametrised xvec register file.
// Holds the clear-engine state encoding and the lane slicing helper.
package xvec_rf_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } clr_state_t;

    localparam int XLEN_DEF   = 32;
    localparam int NLANES_DEF = 29;
    localparam int NREGS_DEF  = 32;

    // Low bit of lane i; use as vec[lane(i, XLEN) +: XLEN].
    function automatic int lane(input int i, input int xlen);
        return i * xlen;
    endfunction

endpackage

// File: rtl/vscale_vregfile_read_port.sv
// One combinational read port: zero/busy gating, scalar/vector packing and,
// when XVEC_RF_BYPASS_EN is defined, same-cycle write-to-read forwarding.
module vscale_vregfile_read_port
    import xvec_rf_pkg::*;
#(
    parameter int XLEN        = XLEN_DEF,
    parameter int NLANES      = NLANES_DEF,
    parameter int NREGS       = NREGS_DEF,
    parameter int ADDR_W      = 5,
    parameter int SCALAR_LANE = 1
) (
    input  logic [ADDR_W-1:0]      ra,
    input  logic                   mode,
    input  logic                   busy,
    input  logic [NLANES*XLEN-1:0] row,
    input  logic                   byp_en,
    input  logic [ADDR_W-1:0]      wa,
    input  logic [NLANES-1:0]      wlane,
    input  logic [NLANES*XLEN-1:0] wval,
    output logic [NLANES*XLEN-1:0] rd
);

`ifdef XVEC_RF_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [NLANES*XLEN-1:0] merged;
    logic                   hit;
    logic                   valid;

    assign hit   = BYPASS && byp_en && (ra == wa);
    assign valid = (ra != '0) && (32'(ra) < NREGS) && !busy;

    always_comb begin
        merged = row;
        for (int i = 0; i < NLANES; i++) begin
            if (hit && wlane[i]) begin
                merged[lane(i, XLEN) +: XLEN] = wval[lane(i, XLEN) +: XLEN];
            end
        end
        rd = '0;
        if (valid) begin
            if (mode) begin
                rd = merged;
            end else begin
                rd[XLEN-1:0] = merged[lane(SCALAR_LANE, XLEN) +: XLEN];
            end
        end
    end

endmodule

// File: rtl/vscale_vregfile_xvec.sv
// Parametrised xvec register file: NREGS x NLANES x XLEN storage, masked writes,
// two read ports and a sequential clear engine. Optional macro: XVEC_RF_BYPASS_EN.
module vscale_vregfile_xvec
    import xvec_rf_pkg::*;
#(
    parameter int XLEN        = XLEN_DEF,
    parameter int NLANES      = NLANES_DEF,
    parameter int NREGS       = NREGS_DEF,
    parameter int ADDR_W      = 5,
    parameter int SCALAR_LANE = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear_req,
    output logic                   busy,
    input  logic [ADDR_W-1:0]      ra1,
    output logic [NLANES*XLEN-1:0] rd1,
    input  logic [ADDR_W-1:0]      ra2,
    output logic [NLANES*XLEN-1:0] rd2,
    input  logic                   wen,
    input  logic [ADDR_W-1:0]      wa,
    input  logic [NLANES*XLEN-1:0] wd,
    input  logic [NLANES-1:0]      wmask,
    input  logic                   xvec_mode_DX,
    input  logic                   xvec_mode_WB
);

    clr_state_t             state;
    logic [ADDR_W-1:0]      clr_ptr;
    logic [NLANES*XLEN-1:0] data [NREGS];
    logic [NLANES*XLEN-1:0] row1;
    logic [NLANES*XLEN-1:0] row2;
    logic [NLANES*XLEN-1:0] wval;
    logic [NLANES-1:0]      wlane;
    logic                   wr_ok;

    assign wr_ok = wen && (wa != '0) && (32'(wa) < NREGS) && !busy && !reset;

    // Scalar writes replicate the low lane so every lane slot sees wd[XLEN-1:0].
    assign wval = xvec_mode_WB ? wd : {NLANES{wd[XLEN-1:0]}};

    always_comb begin
        wlane = '0;
        for (int i = 0; i < NLANES; i++) begin
            wlane[i] = xvec_mode_WB ? wmask[i] : (i == SCALAR_LANE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CLEAR;
            clr_ptr <= ADDR_W'(1);
            busy    <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    if (32'(clr_ptr) == NREGS - 1) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        clr_ptr <= clr_ptr + 1'b1;
                    end
                end
                IDLE: begin
                    if (clear_req) begin
                        state   <= CLEAR;
                        clr_ptr <= ADDR_W'(1);
                        busy    <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Register 0 is never written; the read ports force it to zero.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            data[clr_ptr] <= '0;
        end else if (wr_ok) begin
            for (int i = 0; i < NLANES; i++) begin
                if (wlane[i]) begin
                    data[wa][lane(i, XLEN) +: XLEN] <= wval[lane(i, XLEN) +: XLEN];
                end
            end
        end
    end

    assign row1 = data[ra1];
    assign row2 = data[ra2];

    vscale_vregfile_read_port #(
        .XLEN(XLEN), .NLANES(NLANES), .NREGS(NREGS),
        .ADDR_W(ADDR_W), .SCALAR_LANE(SCALAR_LANE)
    ) u_rp1 (
        .ra(ra1), .mode(xvec_mode_DX), .busy(busy), .row(row1),
        .byp_en(wr_ok), .wa(wa), .wlane(wlane), .wval(wval), .rd(rd1)
    );

    vscale_vregfile_read_port #(
        .XLEN(XLEN), .NLANES(NLANES), .NREGS(NREGS),
        .ADDR_W(ADDR_W), .SCALAR_LANE(SCALAR_LANE)
    ) u_rp2 (
        .ra(ra2), .mode(xvec_mode_DX), .busy(busy), .row(row2),
        .byp_en(wr_ok), .wa(wa), .wlane(wlane), .wval(wval), .rd(rd2)
    );

endmodule
